fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Front-end controller that owns the program counter of the 5-stage pipeline and sequences instruction fetch. It arbitrates between sequential advance, EX-stage branch/jump redirects, trap entry and hazard stalls. It drives a single-outstanding request/response instruction-memory port and presents fetched instructions to the IF/ID register. Stale responses left in flight by a redirect are discarded.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VEC, 32'h0000_0100, fetch target on trap
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit hold; blocks new issue and holds if_* outputs
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- ex_is_jump  in  1  1: offset is 20-bit jump; 0: offset[11:0] is branch offset
- ex_pc  in  32  PC of the redirecting instruction
- ex_offset  in  20  signed byte offset
- trap  in  1  trap entry request
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction returned (exactly one per accepted request, ≥1 cycle later)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction valid toward IF/ID
- if_pc  out  32  PC of if_instr
- if_instr  out  32  instruction word
- flush  out  1  one-cycle kill of IF/ID and ID/EX

## Operation
- Registers: pc (next fetch address), inflight_pc, state, output slot (if_valid/if_pc/if_instr), one-entry skid (skid_valid/pc/instr).
- States: REQ (ready to issue), WAIT (one request outstanding, response wanted), DROP (one request outstanding, response to discard).
- imem_req_valid = (state==REQ) && !stall && !skid_valid; imem_req_addr = pc. Memory samples addr only on valid&&ready; addr may change between unaccepted cycles.
- Redirect priority: trap > ex_redirect > sequential. Target: trap → TRAP_VEC; jump → ex_pc + sext(ex_offset[19:0]); branch → ex_pc + sext(ex_offset[11:0]); target[1:0] forced to 0. Adds are 32-bit, wrap modulo 2^32.
- Any redirect (trap or ex_redirect): pc <= target; flush=1 same cycle (combinational); if_valid and skid_valid cleared next edge; accept in that cycle is treated as stale.
- REQ: on accept without redirect → inflight_pc<=pc, pc<=pc+4 (wraps), WAIT. Accept with redirect → DROP. No accept → stay.
- WAIT: response without redirect → deliver (inflight_pc, data), REQ. Response with redirect → discard, REQ. Redirect without response → DROP.
- DROP: response → discard, REQ; further redirects update pc only.
- Delivery: if output slot empty or stall=0, load output slot; else load skid. Output slot consumed in each cycle stall=0; on consume, skid (if valid) moves to output slot.

## Timing
- Reset (async): pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_instr=0, skid_valid=0, imem_req_valid=0 while rst_n=0, imem_req_addr=RESET_PC, flush=0.
- First request: first cycle after rst_n release, addr RESET_PC.
- Latency: response in cycle N → if_valid=1 from cycle N+1.
- Back-to-back: next request may issue the cycle after the response (REQ), giving one instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N → flush=1 in N; first request to target in N+1 (REQ) or after the stale response returns (DROP).
- Reset mid-operation: all state cleared; any later response to a pre-reset request is not supported (memory reset together).

## Test plan
- Reset release, ready=1, 1-cycle memory returning 32'h00000013 → requests at 0x0, 0x4, 0x8; if_pc 0x0, 0x4, 0x8 with if_valid pulses.
- Branch redirect in WAIT, ex_pc=0x10, ex_is_jump=0, ex_offset=20'h00FF8 (-8) → flush pulse, response dropped, next request addr 0x8.
- Jump ex_pc=0x20, ex_offset=20'h00100 → next request 0x120; jump with ex_offset=20'hFFFFC from ex_pc=0x0 → wraps to 0xFFFF_FFFC.
- Trap and ex_redirect same cycle → target TRAP_VEC=0x100, single flush pulse.
- stall=1 while response arrives with output slot full → held in skid, no new request; stall=0 → slot then skid delivered on consecutive cycles, issue resumes.
- Assert rst_n=0 in WAIT → outputs return to reset values immediately; after release first request addr RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory port of the fetch sequencer: single-outstanding
// request/response handshake between the sequencer (master) and memory (slave).
interface fetch_sequencer_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer for the 5-stage pipeline:
// arbitrates trap / EX redirect / sequential advance and discards stale responses.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       ex_redirect,
    input  logic                       ex_is_jump,
    input  logic [31:0]                ex_pc,
    input  logic [19:0]                ex_offset,
    input  logic                       trap,
    fetch_sequencer_if.master          imem,
    output logic                       if_valid,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_instr,
    output logic                       flush
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] inflight_pc_r;

    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        skid_valid_r;
    logic [31:0] skid_pc_r;
    logic [31:0] skid_instr_r;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] offset_s;
    logic        req_valid_s;
    logic        accept_s;
    logic        rsp_s;
    logic        deliver_s;

    // Word-align a fetch target (instructions are 4-byte aligned).
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    assign redirect_s  = trap | ex_redirect;
    assign rsp_s       = imem.imem_rsp_valid;
    // Issue is suppressed during reset so the port is quiet while rst_n is low.
    assign req_valid_s = rst_n & (state_r == ST_REQ) & ~stall & ~skid_valid_r;
    assign accept_s    = req_valid_s & imem.imem_req_ready;
    assign deliver_s   = (state_r == ST_WAIT) & rsp_s & ~redirect_s;

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_req_addr  = pc_r;
    assign flush               = rst_n & redirect_s;
    assign if_valid            = if_valid_r;
    assign if_pc               = if_pc_r;
    assign if_instr            = if_instr_r;

    // Redirect target: trap beats EX; branches use only the low 12 offset bits.
    always_comb begin
        offset_s = 32'h0000_0000;
        target_s = 32'h0000_0000;
        if (ex_is_jump) begin
            offset_s = {{12{ex_offset[19]}}, ex_offset};
        end else begin
            offset_s = {{20{ex_offset[11]}}, ex_offset[11:0]};
        end
        if (trap) begin
            target_s = align_word(TRAP_VEC);
        end else begin
            target_s = align_word(ex_pc + offset_s);
        end
    end

    // Next fetch address: redirect wins, otherwise advance on an accepted request.
    always_comb begin
        pc_nxt_s = pc_r;
        if (redirect_s) begin
            pc_nxt_s = target_s;
        end else if (accept_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Request/response sequencing; a redirect turns any outstanding request stale.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (accept_s) begin
                    if (redirect_s) begin
                        state_nxt_s = ST_DROP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_s) begin
                    state_nxt_s = ST_REQ;
                end else if (redirect_s) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (rsp_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // State, fetch PC and the PC of the request currently in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            inflight_pc_r <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            if (accept_s) begin
                inflight_pc_r <= pc_r;
            end
        end
    end

    // Output slot plus one-entry skid; a stalled full slot diverts delivery to the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r   <= 1'b0;
            if_pc_r      <= 32'h0000_0000;
            if_instr_r   <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
        end else if (redirect_s) begin
            if_valid_r   <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!stall) begin
            if (skid_valid_r) begin
                if_valid_r   <= 1'b1;
                if_pc_r      <= skid_pc_r;
                if_instr_r   <= skid_instr_r;
                skid_valid_r <= deliver_s;
                skid_pc_r    <= inflight_pc_r;
                skid_instr_r <= imem.imem_rsp_data;
            end else if (deliver_s) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= inflight_pc_r;
                if_instr_r <= imem.imem_rsp_data;
            end else begin
                if_valid_r <= 1'b0;
            end
        end else if (deliver_s) begin
            if (!if_valid_r) begin
                if_valid_r <= 1'b1;
                if_pc_r    <= inflight_pc_r;
                if_instr_r <= imem.imem_rsp_data;
            end else begin
                skid_valid_r <= 1'b1;
                skid_pc_r    <= inflight_pc_r;
                skid_instr_r <= imem.imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue-based fetch model checked every
// cycle, a latency-programmable memory, and directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_redirect;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic [19:0] ex_offset;
    logic        trap;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .ex_redirect (ex_redirect),
        .ex_is_jump  (ex_is_jump),
        .ex_pc       (ex_pc),
        .ex_offset   (ex_offset),
        .trap        (trap),
        .imem        (bus),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .flush       (flush)
    );

    int tests = 0;
    int fails = 0;
    int mem_lat = 1;
    int cnum = 0;
    int flush_cnt = 0;

    logic [31:0] req_log[$];
    logic [31:0] req_cyc[$];
    logic [31:0] dv_pc[$];
    logic [31:0] dv_ins[$];
    logic [31:0] dv_cyc[$];

    // Model state: next fetch PC, one outstanding request, queue of instructions held.
    logic [31:0] m_pc;
    logic        m_busy;
    logic        m_stale;
    logic [31:0] m_ipc;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) cnum = 0;
            else cnum = cnum + 1;
        end
    end

    // Memory: one outstanding request, response exactly mem_lat cycles after accept.
    initial begin
        logic        pend;
        int          rem;
        logic [31:0] paddr;
        pend = 1'b0;
        rem = 0;
        paddr = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                rem = rem - 1;
                if (rem == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend  = 1'b1;
                rem   = mem_lat;
                paddr = bus.imem_req_addr;
                req_log.push_back(bus.imem_req_addr);
                req_cyc.push_back(cnum);
            end
        end
    end

    // Compare process: check every cycle against the model, then advance the model.
    initial begin
        logic        redir;
        logic        e_rv;
        logic        acc;
        logic        dlv;
        logic [31:0] off;
        logic [31:0] tgt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
                chk("rst req_addr", bus.imem_req_addr, RESET_PC);
                chk("rst flush", {31'd0, flush}, 32'd0);
                chk("rst if_valid", {31'd0, if_valid}, 32'd0);
                chk("rst if_pc", if_pc, 32'd0);
                chk("rst if_instr", if_instr, 32'd0);
                m_pc = RESET_PC;
                m_busy = 1'b0;
                m_stale = 1'b0;
                m_ipc = 32'd0;
                q_pc.delete();
                q_ins.delete();
            end else begin
                redir = trap || ex_redirect;
                e_rv  = !m_busy && !stall && (q_pc.size() < 2);
                chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, e_rv});
                chk("req_addr", bus.imem_req_addr, m_pc);
                chk("flush", {31'd0, flush}, {31'd0, redir});
                chk("if_valid", {31'd0, if_valid}, {31'd0, q_pc.size() > 0});
                if (q_pc.size() > 0) begin
                    chk("if_pc", if_pc, q_pc[0]);
                    chk("if_instr", if_instr, q_ins[0]);
                end
                if (if_valid && !stall) begin
                    dv_pc.push_back(if_pc);
                    dv_ins.push_back(if_instr);
                    dv_cyc.push_back(cnum);
                end
                if (flush) flush_cnt++;

                if (ex_is_jump) off = (ex_offset[19]) ? (32'(ex_offset) - 32'h0010_0000) : 32'(ex_offset);
                else off = (ex_offset[11]) ? (32'(ex_offset[11:0]) - 32'h0000_1000) : 32'(ex_offset[11:0]);
                tgt = trap ? TRAP_VEC : ((ex_pc + off) & 32'hFFFF_FFFC);

                acc = e_rv && bus.imem_req_ready;
                dlv = bus.imem_rsp_valid && m_busy && !m_stale && !redir;
                if (bus.imem_rsp_valid) m_busy = 1'b0;
                if (!stall && q_pc.size() > 0) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (dlv) begin
                    q_pc.push_back(m_ipc);
                    q_ins.push_back(bus.imem_rsp_data);
                end
                if (redir) begin
                    q_pc.delete();
                    q_ins.delete();
                    if (m_busy) m_stale = 1'b1;
                end
                if (acc) begin
                    m_busy  = 1'b1;
                    m_stale = redir;
                    m_ipc   = m_pc;
                end
                m_pc = redir ? tgt : (acc ? m_pc + 32'd4 : m_pc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        stall = 1'b0;
        trap = 1'b0;
        ex_redirect = 1'b0;
        ex_is_jump = 1'b0;
        ex_pc = 32'h0;
        ex_offset = 20'h0;
    endtask

    task automatic clr_logs;
        req_log.delete();
        req_cyc.delete();
        dv_pc.delete();
        dv_ins.delete();
        dv_cyc.delete();
        flush_cnt = 0;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_logs();
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        bus.imem_req_ready = 1'b1;

        // Sequential fetch with a 1-cycle memory.
        mem_lat = 1;
        do_reset();
        cyc(7);
        chk("seq req0", at(req_log, 0), 32'h0);
        chk("seq req1", at(req_log, 1), 32'h4);
        chk("seq req2", at(req_log, 2), 32'h8);
        chk("seq req1 cycle", at(req_cyc, 1), 32'd2);
        chk("seq if_pc0", at(dv_pc, 0), 32'h0);
        chk("seq if_pc1", at(dv_pc, 1), 32'h4);
        chk("seq if_pc2", at(dv_pc, 2), 32'h8);
        chk("seq instr0", at(dv_ins, 0), 32'h0000_0013);
        chk("seq instr1", at(dv_ins, 1), 32'h0000_0413);
        chk("seq if cycle0", at(dv_cyc, 0), 32'd2);

        // Backward branch while waiting on a slow response.
        mem_lat = 3;
        do_reset();
        cyc(1);
        ex_redirect = 1'b1;
        ex_is_jump = 1'b0;
        ex_pc = 32'h10;
        ex_offset = 20'h00FF8;
        cyc(1);
        clr_in();
        cyc(10);
        chk("br req1", at(req_log, 1), 32'h8);
        chk("br req1 cycle", at(req_cyc, 1), 32'd4);
        chk("br first if_pc", at(dv_pc, 0), 32'h8);
        chk("br first if cycle", at(dv_cyc, 0), 32'd8);
        chk("br flush count", flush_cnt, 32'd1);

        // Jumps, including a negative offset wrapping below zero.
        mem_lat = 1;
        do_reset();
        ex_redirect = 1'b1;
        ex_is_jump = 1'b1;
        ex_pc = 32'h20;
        ex_offset = 20'h00100;
        cyc(1);
        clr_in();
        cyc(4);
        ex_redirect = 1'b1;
        ex_is_jump = 1'b1;
        ex_pc = 32'h0;
        ex_offset = 20'hFFFFC;
        cyc(1);
        clr_in();
        cyc(6);
        chk("jmp req1", at(req_log, 1), 32'h120);
        chk("jmp req2", at(req_log, 2), 32'h124);
        chk("jmp wrap req3", at(req_log, 3), 32'hFFFF_FFFC);
        chk("jmp wrap req4", at(req_log, 4), 32'h0);
        chk("jmp if_pc0", at(dv_pc, 0), 32'h120);
        chk("jmp if_pc1", at(dv_pc, 1), 32'hFFFF_FFFC);
        chk("jmp instr1", at(dv_ins, 1), 32'hFFFF_FC13);
        chk("jmp if cycle1", at(dv_cyc, 1), 32'd8);
        chk("jmp flush count", flush_cnt, 32'd2);

        // Trap and EX redirect together: trap vector wins, one flush.
        do_reset();
        cyc(2);
        trap = 1'b1;
        ex_redirect = 1'b1;
        ex_is_jump = 1'b0;
        ex_pc = 32'h40;
        ex_offset = 20'h00008;
        cyc(1);
        clr_in();
        cyc(6);
        chk("trap req2", at(req_log, 2), 32'h100);
        chk("trap req2 cycle", at(req_cyc, 2), 32'd4);
        chk("trap if_pc1", at(dv_pc, 1), 32'h100);
        chk("trap flush count", flush_cnt, 32'd1);

        // Stall across the response: output held, issue blocked until release.
        do_reset();
        cyc(1);
        stall = 1'b1;
        cyc(3);
        stall = 1'b0;
        cyc(4);
        chk("stall req1 cycle", at(req_cyc, 1), 32'd4);
        chk("stall if cycle0", at(dv_cyc, 0), 32'd4);
        chk("stall if_pc1", at(dv_pc, 1), 32'h4);
        chk("stall if cycle1", at(dv_cyc, 1), 32'd6);

        // Asynchronous reset while a request is outstanding.
        mem_lat = 3;
        do_reset();
        cyc(1);
        chk("pre-reset addr", bus.imem_req_addr, 32'h4);
        rst_n = 1'b0;
        ex_redirect = 1'b1;
        #1;
        chk("async rst req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("async rst addr", bus.imem_req_addr, 32'h0);
        chk("async rst if_valid", {31'd0, if_valid}, 32'd0);
        chk("async rst flush", {31'd0, flush}, 32'd0);
        cyc(2);
        clr_in();
        rst_n = 1'b1;
        clr_logs();
        cyc(3);
        chk("post-reset req0", at(req_log, 0), 32'h0);
        chk("post-reset req0 cycle", at(req_cyc, 0), 32'd0);
        chk("post-reset single req", at(req_log, 1), 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
